// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Hazard detection and forwarding controller for a 5-stage (F/D/E/M/W)
// pipeline. It works on the Tuse/Tnew principle:
//   - Tuse is how many cycles the D-stage instruction has before it needs an
//     operand.
//   - Tnew is how many cycles an in-flight instruction has before its result
//     exists.
//
// The block keeps a small record {a1, a2, a3, tnew} for the instructions in
// E, M and W. From those records it derives:
//   - the D-stage stall / E-bubble controls;
//   - the operand forwarding selects for the D, E and M stages.
//
// An optional multiply/divide busy tracker holds back instructions that use
// HI/LO or the MD unit while a mult/div is still running.
//
// Optional feature macro: HAZARD_MD_EN
//   Defined  : the MD down-counter and the md_use stall are built.
//   Undefined: the md_* inputs are ignored and md_busy is tied low.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   rs_d, rt_d             D-stage source register addresses
//   tuse_rs_d, tuse_rt_d   cycles until the operand is consumed
//                          (all-ones = operand not read)
//   a3_d, tnew_d           D-stage destination (0 = no write) and its Tnew
//   md_start_d, md_div_d   D instruction starts a mult (div=0) or div (div=1)
//   md_use_d               D instruction touches HI/LO or the MD unit
//   stall                  D stage held
//   en_pc, en_d            PC / D-register write enables (= !stall)
//   clr_e                  bubble into E (= stall)
//   fwd_rs_d, fwd_rt_d     D operand source: 0 regfile, 1 E, 2 M, 3 W
//   fwd_rs_e, fwd_rt_e     E operand source: 0 pipeline reg, 2 M, 3 W
//   fwd_rt_m               M store-data source: 0 pipeline reg, 3 W
//   md_busy                MD unit running
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_AW      = 5,
  parameter int TNEW_W      = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [TNEW_W-1:0] tuse_rs_d,
  input  logic [TNEW_W-1:0] tuse_rt_d,
  input  logic [REG_AW-1:0] a3_d,
  input  logic [TNEW_W-1:0] tnew_d,
  input  logic              md_start_d,
  input  logic              md_div_d,
  input  logic              md_use_d,
  output logic              stall,
  output logic              en_pc,
  output logic              en_d,
  output logic              clr_e,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic [1:0]        fwd_rt_m,
  output logic              md_busy
);

  typedef struct packed {
    logic [REG_AW-1:0] a1;
    logic [REG_AW-1:0] a2;
    logic [REG_AW-1:0] a3;
    logic [TNEW_W-1:0] tnew;
  } stage_rec_t;

  localparam logic [TNEW_W-1:0] TUSE_NONE = '1;

  stage_rec_t e_q, m_q, w_q;
  stage_rec_t e_d, m_d, w_d;
  logic       hz_stall;
  logic       md_stall;

  // Remaining Tnew after one more stage of travel, floored at zero.
  function automatic logic [TNEW_W-1:0] age_tnew(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // An operand must wait if a producer in E or M will not have its result
  // ready by the time the operand is consumed. A producer in W always has
  // its result by now, so W is never checked.
  function automatic logic operand_stall(input logic [REG_AW-1:0] addr,
                                         input logic [TNEW_W-1:0] tuse,
                                         input stage_rec_t        e,
                                         input stage_rec_t        m);
    logic reads;
    reads = (tuse != TUSE_NONE) && (addr != '0);
    return reads && (((addr == e.a3) && (e.tnew > tuse)) ||
                     ((addr == m.a3) && (m.tnew > tuse)));
  endfunction

  // A stage can supply a value once its result exists; $0 never forwards.
  function automatic logic src_ready(input logic [REG_AW-1:0] addr,
                                     input stage_rec_t        s);
    return (addr != '0) && (s.a3 == addr) && (s.tnew == '0);
  endfunction

  always_comb begin
    hz_stall = operand_stall(rs_d, tuse_rs_d, e_q, m_q) |
               operand_stall(rt_d, tuse_rt_d, e_q, m_q);
  end

  always_comb begin
    stall = hz_stall | md_stall;
    en_pc = ~stall;
    en_d  = ~stall;
    clr_e = stall;
  end

  // Youngest eligible producer wins: E over M over W.
  always_comb begin
    fwd_rs_d = 2'd0;
    if      (src_ready(rs_d, e_q)) fwd_rs_d = 2'd1;
    else if (src_ready(rs_d, m_q)) fwd_rs_d = 2'd2;
    else if (src_ready(rs_d, w_q)) fwd_rs_d = 2'd3;

    fwd_rt_d = 2'd0;
    if      (src_ready(rt_d, e_q)) fwd_rt_d = 2'd1;
    else if (src_ready(rt_d, m_q)) fwd_rt_d = 2'd2;
    else if (src_ready(rt_d, w_q)) fwd_rt_d = 2'd3;

    fwd_rs_e = 2'd0;
    if      (src_ready(e_q.a1, m_q)) fwd_rs_e = 2'd2;
    else if (src_ready(e_q.a1, w_q)) fwd_rs_e = 2'd3;

    fwd_rt_e = 2'd0;
    if      (src_ready(e_q.a2, m_q)) fwd_rt_e = 2'd2;
    else if (src_ready(e_q.a2, w_q)) fwd_rt_e = 2'd3;

    fwd_rt_m = 2'd0;
    if (src_ready(m_q.a2, w_q)) fwd_rt_m = 2'd3;
  end

  // A held D instruction enters E as an all-zero bubble. M and W always
  // advance, so a stall only ever delays the D instruction itself.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.a1   = rs_d;
      e_d.a2   = rt_d;
      e_d.a3   = a3_d;
      e_d.tnew = tnew_d;
    end
    m_d      = e_q;
    m_d.tnew = age_tnew(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = age_tnew(m_q.tnew);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // W source addresses have no consumer past W.
  logic unused_rec;
  assign unused_rec = ^{w_q.a1, w_q.a2};

`ifdef HAZARD_MD_EN
  localparam logic [15:0] MULT_LOAD = 16'(MULT_CYCLES);
  localparam logic [15:0] DIV_LOAD  = 16'(DIV_CYCLES);

  logic        e_md_start_q;
  logic        e_md_div_q;
  logic [15:0] md_cnt_q;
  logic [15:0] md_cnt_d;

  always_comb begin
    if (e_md_start_q)            md_cnt_d = e_md_div_q ? DIV_LOAD : MULT_LOAD;
    else if (md_cnt_q != 16'd0)  md_cnt_d = md_cnt_q - 16'd1;
    else                         md_cnt_d = 16'd0;
  end

  // The unit counts as busy from the cycle the mult/div sits in E, before
  // the counter has been loaded.
  always_comb begin
    md_busy  = (md_cnt_q != 16'd0) | e_md_start_q;
    md_stall = md_use_d & md_busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
      md_cnt_q     <= 16'd0;
    end else begin
      e_md_start_q <= md_start_d & ~stall;
      e_md_div_q   <= md_div_d & ~stall;
      md_cnt_q     <= md_cnt_d;
    end
  end
`else
  always_comb begin
    md_busy  = 1'b0;
    md_stall = 1'b0;
  end

  logic unused_md;
  assign unused_md = ^{md_start_d, md_div_d, md_use_d,
                       32'(MULT_CYCLES), 32'(DIV_CYCLES)};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int AW      = 5;
  localparam int TW      = 2;
  localparam int MULTC   = 5;
  localparam int DIVC    = 10;
  localparam int TU_NONE = 3;
`ifdef HAZARD_MD_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rs_d, rt_d, a3_d;
  logic [TW-1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic          md_start_d, md_div_d, md_use_d;
  logic          stall, en_pc, en_d, clr_e, md_busy;
  logic [1:0]    fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  always #5 clk = ~clk;

  hazard_unit #(
    .REG_AW(AW), .TNEW_W(TW), .MULT_CYCLES(MULTC), .DIV_CYCLES(DIVC)
  ) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .a3_d(a3_d), .tnew_d(tnew_d),
    .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
    .stall(stall), .en_pc(en_pc), .en_d(en_d), .clr_e(clr_e),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .md_busy(md_busy)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Model: the in-flight instructions are kept by age since entering E
  // (index 0 = E, 1 = M, 2 = W), each with its original Tnew. Remaining Tnew
  // is Tnew minus age. MD busy is tracked as the last cycle number the unit
  // is still running.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int a1;
    int a2;
    int a3;
    int tnew;
    bit mds;
    bit mdd;
  } ent_t;

  ent_t pipe[3];
  int   cyc = 0;
  int   md_until = -1000;

  function automatic int rem(input int age);
    int r;
    r = pipe[age].tnew - age;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic int src(input int x, input int first_age);
    for (int i = first_age; i < 3; i++)
      if (x != 0 && pipe[i].a3 == x && rem(i) == 0) return i + 1;
    return 0;
  endfunction

  function automatic bit waits_on(input int x, input int tuse);
    if (tuse == TU_NONE || x == 0) return 1'b0;
    for (int i = 0; i < 2; i++)
      if (pipe[i].a3 == x && rem(i) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    return MD_ON && (pipe[0].mds || cyc <= md_until);
  endfunction

  function automatic bit m_stall();
    return waits_on(int'(rs_d), int'(tuse_rs_d)) ||
           waits_on(int'(rt_d), int'(tuse_rt_d)) ||
           (MD_ON && md_use_d && m_busy());
  endfunction

  always @(posedge clk) begin : model_upd
    ent_t dent;
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] <= '0;
      md_until <= -1000;
    end else begin
      dent = '0;
      if (!m_stall()) begin
        dent.a1   = int'(rs_d);
        dent.a2   = int'(rt_d);
        dent.a3   = int'(a3_d);
        dent.tnew = int'(tnew_d);
        dent.mds  = MD_ON && md_start_d;
        dent.mdd  = md_div_d;
      end
      if (pipe[0].mds) md_until <= cyc + (pipe[0].mdd ? DIVC : MULTC);
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      pipe[0] <= dent;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin : compare
    bit s;
    if (!reset) begin
      s = m_stall();
      chk("stall",    int'(stall),    int'(s));
      chk("en_pc",    int'(en_pc),    int'(!s));
      chk("en_d",     int'(en_d),     int'(!s));
      chk("clr_e",    int'(clr_e),    int'(s));
      chk("fwd_rs_d", int'(fwd_rs_d), src(int'(rs_d), 0));
      chk("fwd_rt_d", int'(fwd_rt_d), src(int'(rt_d), 0));
      chk("fwd_rs_e", int'(fwd_rs_e), src(pipe[0].a1, 1));
      chk("fwd_rt_e", int'(fwd_rt_e), src(pipe[0].a2, 1));
      chk("fwd_rt_m", int'(fwd_rt_m), src(pipe[1].a2, 2));
      chk("md_busy",  int'(md_busy),  int'(m_busy()));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input int rs, input int rt, input int trs, input int trt,
                       input int a3, input int tn, input int ms, input int md,
                       input int mu);
    rs_d       = AW'(rs);
    rt_d       = AW'(rt);
    tuse_rs_d  = TW'(trs);
    tuse_rt_d  = TW'(trt);
    a3_d       = AW'(a3);
    tnew_d     = TW'(tn);
    md_start_d = ms[0];
    md_div_d   = md[0];
    md_use_d   = mu[0];
  endtask

  // Present one instruction in D, hold it while stalled, and check the
  // hand-computed stall count and (optionally) one output at the issue cycle.
  // sig: 0 none, 1 fwd_rs_d, 2 fwd_rt_d, 3 fwd_rs_e, 4 fwd_rt_e, 5 fwd_rt_m.
  task automatic issue(input string nm, input int rs, input int rt,
                       input int trs, input int trt, input int a3, input int tn,
                       input int ms, input int md, input int mu,
                       input int exp_stalls, input int sig, input int val);
    int  n;
    bit  done;
    drive(rs, rt, trs, trt, a3, tn, ms, md, mu);
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (stall) begin
        n++;
        if (n > 40) begin
          chk({nm, "/stall_timeout"}, n, exp_stalls);
          done = 1'b1;
        end else begin
          @(posedge clk);
          #1;
        end
      end else begin
        case (sig)
          1: chk({nm, "/fwd_rs_d"}, int'(fwd_rs_d), val);
          2: chk({nm, "/fwd_rt_d"}, int'(fwd_rt_d), val);
          3: chk({nm, "/fwd_rs_e"}, int'(fwd_rs_e), val);
          4: chk({nm, "/fwd_rt_e"}, int'(fwd_rt_e), val);
          5: chk({nm, "/fwd_rt_m"}, int'(fwd_rt_m), val);
          default: ;
        endcase
        done = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (n <= 40) chk({nm, "/stall_cycles"}, n, exp_stalls);
  endtask

  task automatic nop(input string nm, input int sig, input int val);
    issue(nm, 0, 0, TU_NONE, TU_NONE, 0, 0, 0, 0, 0, 0, sig, val);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) nop("flush", 0, 0);
  endtask

  initial begin
    drive(0, 0, TU_NONE, TU_NONE, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst/stall",    int'(stall),    0);
    chk("rst/en_pc",    int'(en_pc),    1);
    chk("rst/en_d",     int'(en_d),     1);
    chk("rst/clr_e",    int'(clr_e),    0);
    chk("rst/fwd_rs_d", int'(fwd_rs_d), 0);
    chk("rst/fwd_rt_d", int'(fwd_rt_d), 0);
    chk("rst/fwd_rs_e", int'(fwd_rs_e), 0);
    chk("rst/fwd_rt_e", int'(fwd_rt_e), 0);
    chk("rst/fwd_rt_m", int'(fwd_rt_m), 0);
    chk("rst/md_busy",  int'(md_busy),  0);
    @(posedge clk);
    #1;

    //     name       rs  rt  trs trt a3 tn ms md mu stalls sig val
    // load-use, tuse 1: one stall, then W forwards into E
    issue("lw1",      5,  0,  1,  3,  1, 2, 0, 0, 0, 0,     0,  0);
    issue("addu_lu",  1,  3,  1,  1,  2, 1, 0, 0, 0, 1,     0,  0);
    nop("lu_fwd_e", 3, 3);
    flush();
    // ALU result into a branch comparing in D
    issue("addu1",    0,  0,  3,  3,  1, 1, 0, 0, 0, 0,     0,  0);
    issue("beq1",     1,  0,  0,  0,  0, 0, 0, 0, 0, 1,     1,  2);
    flush();
    // back-to-back writers of $1: M beats W
    issue("addu_a",   0,  0,  3,  3,  1, 1, 0, 0, 0, 0,     0,  0);
    issue("addu_b",   0,  0,  3,  3,  1, 1, 0, 0, 0, 0,     0,  0);
    issue("addu_c",   1,  0,  1,  3,  2, 1, 0, 0, 0, 0,     1,  2);
    nop("mw_fwd_e", 3, 2);
    flush();
    // $0 is never a hazard
    issue("wr_r0",    0,  0,  3,  3,  0, 2, 0, 0, 0, 0,     0,  0);
    issue("rd_r0",    0,  0,  0,  0,  0, 0, 0, 0, 0, 0,     1,  0);
    nop("r0_fwd_e", 3, 0);
    flush();
    // load-use, tuse 0: two stalls, then W forwards into D
    issue("lw4",      0,  0,  3,  3,  4, 2, 0, 0, 0, 0,     0,  0);
    issue("beq4",     4,  0,  0,  0,  0, 0, 0, 0, 0, 2,     1,  3);
    flush();
    // store data consumed in M
    issue("lw5",      0,  0,  3,  3,  5, 2, 0, 0, 0, 0,     0,  0);
    issue("sw5",      6,  5,  1,  2,  0, 0, 0, 0, 0, 0,     0,  0);
    nop("sw_fwd_e", 4, 0);
    nop("sw_fwd_m", 5, 3);
    flush();
    // jal (tnew 0) forwards straight from E
    issue("jal",      0,  0,  3,  3, 31, 0, 0, 0, 0, 0,     0,  0);
    issue("jr31",    31,  0,  0,  3,  0, 0, 0, 0, 0, 0,     1,  1);
    flush();
    // three ready producers of $7: E wins in D, then M wins for E
    issue("p7a",      0,  0,  3,  3,  7, 1, 0, 0, 0, 0,     0,  0);
    issue("p7b",      0,  0,  3,  3,  7, 1, 0, 0, 0, 0,     0,  0);
    issue("p7c",      0,  0,  3,  3,  7, 0, 0, 0, 0, 0,     0,  0);
    issue("rd7",      0,  7,  3,  0,  9, 1, 0, 0, 0, 0,     2,  1);
    nop("p7_fwd_e", 4, 2);
    flush();
    // MD unit
    issue("mult",     0,  0,  3,  3,  0, 0, 1, 0, 1, 0,     0,  0);
    issue("mflo",     0,  0,  3,  3,  8, 1, 0, 0, 1, MD_ON ? MULTC + 1 : 0, 0, 0);
    flush();
    issue("div",      0,  0,  3,  3,  0, 0, 1, 1, 1, 0,     0,  0);
    issue("mfhi",     0,  0,  3,  3,  8, 1, 0, 0, 1, MD_ON ? DIVC + 1 : 0, 0, 0);
    flush();

    // reset a few cycles into a divide, with a load hazard pending too
    issue("div_r",    0,  0,  3,  3,  0, 0, 1, 1, 1, 0,     0,  0);
    nop("div_r_n", 0, 0);
    issue("lw9",      0,  0,  3,  3,  9, 2, 0, 0, 0, 0,     0,  0);
    drive(9, 0, 0, TU_NONE, 8, 1, 0, 0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("pre_rst/md_busy", int'(md_busy), int'(MD_ON));
    chk("pre_rst/stall",   int'(stall),   1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst/md_busy",  int'(md_busy),  0);
    chk("post_rst/stall",    int'(stall),    0);
    chk("post_rst/fwd_rs_d", int'(fwd_rs_d), 0);
    @(posedge clk);
    #1;
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard-detection and forwarding controller for the 5-stage (F/D/E/M/W) pipeline. It generalises the Tuse/Tnew stall scheme. It tracks destination register and remaining Tnew for every in-flight instruction in E, M and W, and issues stall/bubble controls plus per-stage forwarding selects. It also adds a multi-cycle multiply/divide busy tracker with configurable latencies. It sits beside the D-stage decoder: the decoder supplies per-instruction register addresses and timing, and this block drives the PC/D-register enables and the datapath forwarding muxes.

## Interface
Parameters:
- REG_AW, 5, register address width
- TNEW_W, 2, width of Tnew/Tuse fields
- MULT_CYCLES, 5, busy cycles after a mult/multu enters E
- DIV_CYCLES, 10, busy cycles after a div/divu enters E

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rs_d  in  REG_AW  D-stage rs address
- rt_d  in  REG_AW  D-stage rt address
- tuse_rs_d  in  TNEW_W  cycles until rs is consumed; all-ones = not read
- tuse_rt_d  in  TNEW_W  same for rt
- a3_d  in  REG_AW  D-stage write address; 0 = no write
- tnew_d  in  TNEW_W  cycles after entering E until result exists (ALU=1, load=2, jal=0)
- md_start_d  in  1  D instruction is mult/div
- md_div_d  in  1  with md_start_d: divide, else multiply
- md_use_d  in  1  D instruction accesses HI/LO or the MD unit
- stall  out  1  D stage held
- en_pc, en_d  out  1  PC / D-register write enables (= !stall)
- clr_e  out  1  insert bubble into E register (= stall)
- fwd_rs_d, fwd_rt_d  out  2  D operand source: 0 regfile, 1 E, 2 M, 3 W
- fwd_rs_e, fwd_rt_e  out  2  E operand source: 0 pipeline reg, 2 M, 3 W
- fwd_rt_m  out  2  M store-data source: 0 pipeline reg, 3 W
- md_busy  out  1  MD unit running

## Operation
- Internal stage records for E, M and W: {a1, a2, a3, tnew}. On each clock, E←D (or a zeroed bubble when stall), M←E, W←M. tnew decrements by 1 per stage and saturates at 0.
- Stall condition for each read operand X in {rs, rt} with tuse ≠ all-ones and X ≠ 0:
  - stall if X == a3_E and tnew_E > tuse, or
  - stall if X == a3_M and tnew_M > tuse.
  - W never stalls.
- Forwarding: a stage is an eligible source when its a3 equals the operand address, a3 ≠ 0, and its tnew == 0. Priority is youngest first: E > M > W. If no source is eligible, select 0.
- $0 is never stalled on and never forwarded.
- MD tracker: a 16-bit down-counter.
  - When the E record is a valid md_start, the counter loads MULT_CYCLES or DIV_CYCLES.
  - Otherwise it decrements to 0.
  - md_busy = counter ≠ 0 or md_start in E.
  - md_use_d with md_busy forces stall.
- Simultaneous stall sources are ORed. A stall never disturbs M/W advance.

## Timing
- stall, enables and all fwd_* outputs are combinational from the current D inputs and registered state, valid in the same cycle.
- Stage records update on the rising clk edge.
- Reset values: all records zero (a3=0, tnew=0); counter 0; stall 0; en_pc/en_d 1; clr_e 0; all fwd_* 0; md_busy 0.
- Reset mid-operation aborts MD busy immediately on the next edge and clears all pending hazards.
- Load-use latency: a consumer with tuse=1 directly after a load stalls exactly 1 cycle; with tuse=0 it stalls 2 cycles.

## Configuration
- HAZARD_MD_EN defined: MD counter and md_use stall are built.
- Undefined: md_start_d, md_div_d and md_use_d are ignored; md_busy is tied 0; there is no counter logic.

## Test plan
- lw $1 (tnew 2), then addu $2,$1,$3 (tuse_rs 1) -> stall=1 for 1 cycle; next cycle fwd_rs_e=3.
- addu $1 (tnew 1), then beq $1,$0 (tuse 0) -> stall 1 cycle; then fwd_rs_d=2.
- addu $1; addu $1; addu $2,$1 -> no stall; fwd_rs_e=2 (M beats W).
- Writer with a3=0 followed by a reader of $0 -> stall=0, all fwd=0.
- mult (HAZARD_MD_EN), then mflo next -> stall held for MULT_CYCLES+1 cycles; div -> DIV_CYCLES+1.
- reset asserted 3 cycles into a div -> md_busy=0 and stall=0 on the cycle after the reset edge.
